// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with an IF/ID register and a one-entry skid buffer.
// Issues one request at a time to instruction memory. It stalls fetching (HOLD) when
// decode back-pressures and both the IF/ID register and the skid buffer are full. It
// drains an outstanding request (DRAIN) after a redirect so that the stale data is dropped.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int OPC_W    = 4,
    parameter int FUNCT_W  = 4,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_ack,
    input  logic [INSTR_W-1:0]        imem_rdata,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    input  logic                      id_ready,
    output logic                      id_valid,
    output logic [INSTR_W-1:0]        id_instr,
    output logic [ADDR_W-1:0]         id_pc,
    output logic [OPC_W-1:0]          id_opcode,
    output logic [FUNCT_W-1:0]        id_funct,
    output logic [INSTR_W-OPC_W-1:0]  id_offset
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_req_addr;
    logic                 r_id_valid;
    logic [INSTR_W-1:0]   r_id_instr;
    logic [ADDR_W-1:0]    r_id_pc;
    logic                 r_skid_valid;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [ADDR_W-1:0]    r_skid_pc;

    state_t               w_state_next;
    logic [ADDR_W-1:0]    w_pc_next;
    logic [ADDR_W-1:0]    w_req_addr_next;
    logic                 w_id_valid_next;
    logic [INSTR_W-1:0]   w_id_instr_next;
    logic [ADDR_W-1:0]    w_id_pc_next;
    logic                 w_skid_valid_next;
    logic [INSTR_W-1:0]   w_skid_instr_next;
    logic [ADDR_W-1:0]    w_skid_pc_next;

    logic                 w_xfer;
    logic                 w_id_free;
    logic [ADDR_W-1:0]    w_req_addr_inc;

    // Request is suppressed while reset is held so that no fetch is cut off mid-flight.
    assign imem_req       = reset && (r_state != HOLD);
    assign imem_addr      = r_req_addr;
    assign w_xfer         = imem_req && imem_ack;
    assign w_id_free      = !r_id_valid || id_ready;
    // Wraps modulo 2^ADDR_W naturally through the fixed result width.
    assign w_req_addr_inc = r_req_addr + STEP;

    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_opcode = r_id_instr[INSTR_W-1 -: OPC_W];
    assign id_funct  = r_id_instr[FUNCT_W-1:0];
    assign id_offset = r_id_instr[INSTR_W-OPC_W-1:0];

    // State and datapath registers; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_pc         <= PC_RESET;
            r_req_addr   <= PC_RESET;
            r_id_valid   <= 1'b0;
            r_id_instr   <= '0;
            r_id_pc      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_addr   <= w_req_addr_next;
            r_id_valid   <= w_id_valid_next;
            r_id_instr   <= w_id_instr_next;
            r_id_pc      <= w_id_pc_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_instr <= w_skid_instr_next;
            r_skid_pc    <= w_skid_pc_next;
        end
    end

    // Next-state and datapath decisions; redirect outranks every other event.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_req_addr_next   = r_req_addr;
        w_id_valid_next   = r_id_valid;
        w_id_instr_next   = r_id_instr;
        w_id_pc_next      = r_id_pc;
        w_skid_valid_next = r_skid_valid;
        w_skid_instr_next = r_skid_instr;
        w_skid_pc_next    = r_skid_pc;

        case (r_state)
            FETCH: begin
                if (redirect_valid) begin
                    w_id_valid_next   = 1'b0;
                    w_skid_valid_next = 1'b0;
                    w_pc_next         = redirect_pc;
                    if (w_xfer) begin
                        // Returned data belongs to the old path; restart at the target.
                        w_req_addr_next = redirect_pc;
                        w_state_next    = FETCH;
                    end else begin
                        // Request still outstanding: keep its address until it completes.
                        w_state_next = DRAIN;
                    end
                end else if (w_xfer) begin
                    w_pc_next       = w_req_addr_inc;
                    w_req_addr_next = w_req_addr_inc;
                    if (w_id_free) begin
                        w_id_valid_next = 1'b1;
                        w_id_instr_next = imem_rdata;
                        w_id_pc_next    = r_req_addr;
                    end else begin
                        w_skid_valid_next = 1'b1;
                        w_skid_instr_next = imem_rdata;
                        w_skid_pc_next    = r_req_addr;
                        w_state_next      = HOLD;
                    end
                end else if (r_id_valid && id_ready) begin
                    w_id_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    w_id_valid_next   = 1'b0;
                    w_skid_valid_next = 1'b0;
                    w_pc_next         = redirect_pc;
                    w_req_addr_next   = redirect_pc;
                    w_state_next      = FETCH;
                end else if (id_ready) begin
                    // Decode takes the IF/ID entry; the skid entry slides in behind it.
                    w_id_valid_next   = 1'b1;
                    w_id_instr_next   = r_skid_instr;
                    w_id_pc_next      = r_skid_pc;
                    w_skid_valid_next = 1'b0;
                    w_state_next      = FETCH;
                end
            end

            DRAIN: begin
                if (redirect_valid) begin
                    w_id_valid_next   = 1'b0;
                    w_skid_valid_next = 1'b0;
                    w_pc_next         = redirect_pc;
                    if (w_xfer) begin
                        // The stale request completes in the same cycle, so no further
                        // ack is coming; restart directly at the newest target.
                        w_req_addr_next = redirect_pc;
                        w_state_next    = FETCH;
                    end
                end else if (w_xfer) begin
                    w_req_addr_next = r_pc;
                    w_state_next    = FETCH;
                end else if (r_id_valid && id_ready) begin
                    w_id_valid_next = 1'b0;
                end
            end

            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against an
// instruction-stream model (program order, redirect targets, memory contents).
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic [3:0]  id_opcode;
    logic [3:0]  id_funct;
    logic [11:0] id_offset;

    int n_checks;
    int n_pass;

    fetch_unit #(
        .ADDR_W(8), .INSTR_W(16), .OPC_W(4), .FUNCT_W(4), .PC_STEP(2), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_offset(id_offset)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents as a function of address.
    function automatic logic [15:0] memf(input logic [7:0] a);
        if (a == 8'h00) return 16'h1234;
        if (a == 8'h02) return 16'h5678;
        return {a ^ 8'h3C, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: drive inputs at negedge (ack only while a request is up), return #1 after posedge.
    task automatic cyc(input logic rst, input logic ack_i, input logic rdy,
                       input logic redir, input logic [7:0] rpc);
        @(negedge clk);
        reset          = rst;
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        imem_ack   = ack_i && imem_req;
        imem_rdata = memf(imem_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  exp_pc;
        logic [15:0] exp_w;
        logic        pend;
        logic [7:0]  pend_addr;
        int          n_deliv;

        n_checks = 0;
        n_pass   = 0;
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Reset state
        cyc(0, 0, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", 32'(id_instr), 32'd0);
        chk("rst_idpc", 32'(id_pc), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        // Zero-wait memory, back-to-back delivery and field slicing
        cyc(1, 1, 1, 0, 8'h00);
        chk("zw_valid", 32'(id_valid), 32'd1);
        chk("zw_pc0", 32'(id_pc), 32'h00);
        chk("zw_instr0", 32'(id_instr), 32'h1234);
        chk("zw_opcode", 32'(id_opcode), 32'h1);
        chk("zw_funct", 32'(id_funct), 32'h4);
        chk("zw_offset", 32'(id_offset), 32'h234);
        chk("zw_addr", 32'(imem_addr), 32'h02);
        cyc(1, 1, 1, 0, 8'h00);
        chk("zw_pc1", 32'(id_pc), 32'h02);
        chk("zw_instr1", 32'(id_instr), 32'h5678);

        // Back-pressure for 3 cycles: IF/ID + skid full, request dropped
        cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 8'h00);
        chk("bp_valid", 32'(id_valid), 32'd1);
        chk("bp_idpc", 32'(id_pc), 32'h00);
        chk("bp_req", 32'(imem_req), 32'd0);
        cyc(1, 1, 1, 0, 8'h00);
        chk("bp_rel_pc", 32'(id_pc), 32'h02);
        chk("bp_rel_req", 32'(imem_req), 32'd1);
        chk("bp_rel_addr", 32'(imem_addr), 32'h04);
        cyc(1, 1, 1, 0, 8'h00);
        chk("bp_third_pc", 32'(id_pc), 32'h04);
        chk("bp_third_instr", 32'(id_instr), 32'h3804);

        // Redirect during a slow fetch: drain the stale ack
        cyc(0, 0, 1, 0, 8'h00);
        cyc(1, 0, 1, 1, 8'h40);
        chk("dr_req", 32'(imem_req), 32'd1);
        chk("dr_addr_held", 32'(imem_addr), 32'h00);
        chk("dr_valid0", 32'(id_valid), 32'd0);
        cyc(1, 0, 1, 0, 8'h00);
        cyc(1, 1, 1, 0, 8'h00);
        chk("dr_stale_dropped", 32'(id_valid), 32'd0);
        chk("dr_new_addr", 32'(imem_addr), 32'h40);
        cyc(1, 1, 1, 0, 8'h00);
        chk("dr_valid1", 32'(id_valid), 32'd1);
        chk("dr_idpc", 32'(id_pc), 32'h40);
        chk("dr_instr", 32'(id_instr), 32'h7C40);

        // Redirect coincident with ack and id_ready
        cyc(1, 1, 1, 1, 8'h10);
        chk("rx_valid", 32'(id_valid), 32'd0);
        chk("rx_addr", 32'(imem_addr), 32'h10);
        cyc(1, 1, 1, 0, 8'h00);
        chk("rx_idpc", 32'(id_pc), 32'h10);

        // PC wrap at the top of the address space
        cyc(1, 1, 1, 1, 8'hFE);
        chk("wr_addr_fe", 32'(imem_addr), 32'hFE);
        cyc(1, 1, 1, 0, 8'h00);
        chk("wr_idpc_fe", 32'(id_pc), 32'hFE);
        chk("wr_addr_00", 32'(imem_addr), 32'h00);
        cyc(1, 1, 1, 0, 8'h00);
        chk("wr_idpc_00", 32'(id_pc), 32'h00);

        // Reset while HOLD with the skid buffer full
        cyc(1, 1, 0, 0, 8'h00);
        chk("rh_hold_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 0, 0, 8'h00);
        chk("rh_valid", 32'(id_valid), 32'd0);
        chk("rh_req", 32'(imem_req), 32'd0);
        chk("rh_instr", 32'(id_instr), 32'd0);
        cyc(1, 1, 1, 0, 8'h00);
        chk("rh_first_valid", 32'(id_valid), 32'd1);
        chk("rh_first_pc", 32'(id_pc), 32'h00);
        chk("rh_first_instr", 32'(id_instr), 32'h1234);
        cyc(1, 0, 1, 0, 8'h00);
        chk("rh_skid_empty", 32'(id_valid), 32'd0);
        chk("rh_next_addr", 32'(imem_addr), 32'h02);

        // Randomized run against the instruction-stream model
        cyc(0, 0, 1, 0, 8'h00);
        exp_pc    = 8'h00;
        pend      = 1'b0;
        pend_addr = 8'h00;
        n_deliv   = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset          = 1'b1;
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom_range(0, 127) << 1);
            #1;
            imem_ack   = imem_req && ($urandom_range(0, 1) == 1);
            imem_rdata = memf(imem_addr);
            #1;
            if (pend)
                chk("rnd_addr_hold", 32'(imem_addr), 32'(pend_addr));
            if (id_valid && id_ready && !redirect_valid) begin
                exp_w = memf(exp_pc);
                chk("rnd_pc", 32'(id_pc), 32'(exp_pc));
                chk("rnd_instr", 32'(id_instr), 32'(exp_w));
                chk("rnd_opcode", 32'(id_opcode), 32'(exp_w[15:12]));
                chk("rnd_offset", 32'(id_offset), 32'(exp_w[11:0]));
                exp_pc  = exp_pc + 8'd2;
                n_deliv++;
            end
            if (redirect_valid)
                exp_pc = redirect_pc;
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
            @(posedge clk);
        end
        chk("rnd_progress", 32'(n_deliv >= 60), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
